ifetch_unit: RTL
================

Name: ifetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction register/decoder.
- Owns the program counter and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned words, with their PCs, in a small queue.
- Presents one instruction per cycle on `inset` with a valid/ready handshake, and accepts branch/jump redirects from execute.

Parameters:
- AW, 16, PC and instruction-memory word-address width.
- RESET_PC, 0, PC value loaded on reset.
- DEPTH, 2, fetch queue entries; only 2 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  AW  word address of the request.
- imem_ack  in  1  memory completes the request; imem_rdata is valid in this cycle.
- imem_rdata  in  32  instruction word.
- inset  out  32  instruction to the decoder.
- inst_pc  out  AW  PC of the instruction on `inset`, used as the JAL link source.
- inst_valid  out  1  `inset` and `inst_pc` are valid.
- inst_ready  in  1  decoder consumes the head entry when `inst_valid` and `inst_ready` are both high.
- redirect  in  1  taken BNZ/BPL/JMP/JAL/JR.
- redirect_pc  in  AW  target word address.

Behaviour:
- Reset (async assert, sync release):
  - pc = RESET_PC; queue empty; FSM = IDLE; discard = 0.
  - imem_req = 0, imem_addr = RESET_PC, inst_valid = 0, inset = 0, inst_pc = 0.
- Word-addressed PC; sequential next is pc+1 mod 2^AW, so 2^AW-1 wraps to 0.
- Memory handshake:
  - Once imem_req is high, it and imem_addr stay constant until a cycle with imem_ack = 1.
  - At most one request is outstanding.
  - imem_ack is legal in the same cycle req rises. imem_ack while imem_req = 0 is ignored.
- FSM states: IDLE, REQ.
  - IDLE -> REQ when count < DEPTH and redirect = 0. Drive imem_req = 1, imem_addr = pc.
  - REQ, no ack: remain in REQ.
  - REQ, ack, discard = 0, no redirect:
    - Push {imem_rdata, imem_addr}; pc = imem_addr+1.
    - If count after push and pop < DEPTH, stay in REQ with imem_addr = pc+1 next cycle (back-to-back, 1 instruction/cycle sustained). Otherwise go to IDLE.
  - REQ, ack, discard = 1: drop the data, clear discard, and go to REQ with imem_addr = pc (already the redirect target).
- Redirect, with priority over everything in that cycle:
  - Flush the queue, so inst_valid = 0 next cycle; pc = redirect_pc.
  - REQ with no ack this cycle: set discard = 1; the request stays stable until its ack, and that data is dropped.
  - REQ with ack this cycle: drop the data and do not set discard; next cycle imem_req = 1 at redirect_pc.
  - IDLE: next cycle imem_req = 1 at redirect_pc.
  - A pop in the redirect cycle still counts as consumed by the decoder.
- Queue:
  - FIFO with count 0..DEPTH.
  - Head drives inset/inst_pc combinationally from registers; inset/inst_pc hold their last value when inst_valid = 0.
  - Push and pop in the same cycle are allowed at any count.
  - Push is never attempted when full, because issue reserves space.
- Latency: ack at cycle N -> inst_valid at N+1 if the queue was empty.
- A second redirect while discard = 1 updates pc only; discard stays 1.

Decomposition:
- Shared package cpu_pkg:
  - Opcode constants (ADD..FPMULT, 6-bit) and field positions (opcode [31:26], Rz [25:21], Ry [20:16], Rx [15:11], Imm [15:0]).
  - WORD_W = 32, AW default, RESET_PC.
- Sub-module fetch_queue: DEPTH-entry FIFO of {32-bit word, AW-bit pc} with push, pop, synchronous flush, count, full, empty.

Test Plan:
- Reset release, memory acks every cycle with rdata = 0x04000000+addr, inst_ready = 1:
  - imem_addr sequence 0, 1, 2, 3.
  - inset 0x04000000, 0x04000001… on consecutive cycles starting 1 cycle after the first ack.
- inst_ready = 0 with zero-wait memory:
  - Exactly 2 entries buffered (pc 0, 1); imem_req drops; no third request.
  - Raising inst_ready drains pc 0, then 1, then fetch resumes at addr 2.
- Memory ack delayed 3 cycles, redirect to 0x0040 asserted in the second wait cycle:
  - imem_addr stays at the old address until ack; that data never appears on inset.
  - Next request at 0x0040.
- Redirect to 0x0100 in the same cycle as an ack at addr 5 with 1 entry queued:
  - Queue flushed; addr-5 data dropped; next cycle imem_req = 1, imem_addr = 0x0100.
- RESET_PC = 0xFFFF, AW = 16, continuous acks: fetch addresses 0xFFFF then 0x0000.
- rst_n asserted mid-REQ with 2 entries queued:
  - Immediately imem_req = 0, inst_valid = 0.
  - After release, the first request is at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, instruction field positions,
// opcode encodings and the fetch FSM state type.
package cpu_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned AW_DEF    = 16;
    localparam int unsigned DEPTH_DEF = 2;
    localparam logic [AW_DEF-1:0] RESET_PC_DEF = '0;

    // Instruction field positions
    localparam int unsigned OPC_W  = 6;
    localparam int unsigned OPC_HI = 31;
    localparam int unsigned OPC_LO = 26;
    localparam int unsigned RZ_HI  = 25;
    localparam int unsigned RZ_LO  = 21;
    localparam int unsigned RY_HI  = 20;
    localparam int unsigned RY_LO  = 16;
    localparam int unsigned RX_HI  = 15;
    localparam int unsigned RX_LO  = 11;
    localparam int unsigned IMM_HI = 15;
    localparam int unsigned IMM_LO = 0;

    typedef enum logic [OPC_W-1:0] {
        OP_ADD    = 6'h00,
        OP_SUB    = 6'h01,
        OP_AND    = 6'h02,
        OP_OR     = 6'h03,
        OP_XOR    = 6'h04,
        OP_SLL    = 6'h05,
        OP_SRL    = 6'h06,
        OP_LDR    = 6'h07,
        OP_STR    = 6'h08,
        OP_BNZ    = 6'h09,
        OP_BPL    = 6'h0A,
        OP_JMP    = 6'h0B,
        OP_JAL    = 6'h0C,
        OP_JR     = 6'h0D,
        OP_FPADD  = 6'h0E,
        OP_FPMULT = 6'h0F
    } opcode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } fetch_state_e;

    // Extract the opcode field of an instruction word
    function automatic opcode_e get_opcode(input logic [WORD_W-1:0] word);
        return opcode_e'(word[OPC_HI:OPC_LO]);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry fetch FIFO holding {instruction word, pc}.
// Ports: i_push/i_push_word/i_push_pc write an entry, i_pop consumes the head,
// i_flush empties the queue synchronously, o_head_* is the head entry,
// o_count/o_full/o_empty report occupancy.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    localparam int unsigned CW   = $clog2(DEPTH + 1),
    localparam int unsigned IW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [WORD_W-1:0] i_push_word,
    input  logic [AW-1:0]     i_push_pc,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic [WORD_W-1:0] o_head_word,
    output logic [AW-1:0]     o_head_pc,
    output logic [CW-1:0]     o_count,
    output logic              o_full,
    output logic              o_empty
);

    logic [WORD_W-1:0] r_word [DEPTH];
    logic [AW-1:0]     r_pc   [DEPTH];
    logic [CW-1:0]     r_count;

    logic              w_pop;
    logic              w_push;
    logic [IW-1:0]     w_wr_idx;

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == CW'(DEPTH));
    assign w_pop    = i_pop & ~o_empty;
    assign w_push   = i_push & (~o_full | w_pop);
    // Write slot is the first free one after this cycle's pop
    assign w_wr_idx = IW'(r_count - CW'(w_pop));

    assign o_head_word = r_word[0];
    assign o_head_pc   = r_pc[0];
    assign o_count     = r_count;

    // Entry 0 is always the head; a pop shifts entry 1 down, and a drain leaves
    // entry 0 untouched so the head holds its last value while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_word[i] <= '0;
                r_pc[i]   <= '0;
            end
        end else if (i_flush) begin
            r_count <= '0;
        end else begin
            if (w_pop && (r_count == CW'(2))) begin
                r_word[0] <= r_word[1];
                r_pc[0]   <= r_pc[1];
            end
            if (w_push) begin
                r_word[w_wr_idx] <= i_push_word;
                r_pc[w_wr_idx]   <= i_push_pc;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory over a
// req/ack handshake, buffers words in a 2-entry queue and hands them to the
// decoder with valid/ready. Execute redirects flush the queue and retarget pc.
// Ports: imem_req/imem_addr/imem_ack/imem_rdata = memory side;
// inset/inst_pc/inst_valid/inst_ready = decoder side;
// redirect/redirect_pc = taken branch/jump from execute.
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned   AW       = AW_DEF,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter int unsigned   DEPTH    = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [AW-1:0]     imem_addr,
    input  logic              imem_ack,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic [WORD_W-1:0] inset,
    output logic [AW-1:0]     inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect,
    input  logic [AW-1:0]     redirect_pc
);

    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned CW1 = CW + 1;

    fetch_state_e   r_state;
    fetch_state_e   w_state_nxt;
    logic [AW-1:0]  r_pc;
    logic [AW-1:0]  w_pc_nxt;
    logic [AW-1:0]  r_addr;
    logic [AW-1:0]  w_addr_nxt;
    logic           r_discard;
    logic           w_discard_nxt;

    logic           w_push;
    logic           w_pop;
    logic           w_ack;
    logic [CW-1:0]  w_q_count;
    logic           w_q_full;
    logic           w_q_empty;
    logic [CW1-1:0] w_cnt_after;

    assign imem_req    = (r_state == ST_REQ);
    assign imem_addr   = r_addr;
    assign inst_valid  = ~w_q_empty;
    assign w_pop       = inst_valid & inst_ready;
    assign w_ack       = imem_req & imem_ack;
    // Occupancy after this cycle's push and pop, used to decide back-to-back issue
    assign w_cnt_after = CW1'(w_q_count) + CW1'(1) - CW1'(w_pop);

    // State and fetch-tracking registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pc      <= RESET_PC;
            r_addr    <= RESET_PC;
            r_discard <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_addr    <= w_addr_nxt;
            r_discard <= w_discard_nxt;
        end
    end

    // Next-state, request address and queue push decisions
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_addr_nxt    = r_addr;
        w_discard_nxt = r_discard;
        w_push        = 1'b0;

        if (redirect) begin
            w_pc_nxt = redirect_pc;
            if ((r_state == ST_REQ) && !w_ack) begin
                // Request must stay stable until acked; its data is stale
                w_discard_nxt = 1'b1;
            end else begin
                w_state_nxt   = ST_REQ;
                w_addr_nxt    = redirect_pc;
                w_discard_nxt = 1'b0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_q_full) begin
                        w_state_nxt = ST_REQ;
                        w_addr_nxt  = r_pc;
                    end
                end
                ST_REQ: begin
                    if (w_ack) begin
                        if (r_discard) begin
                            // pc already holds the redirect target
                            w_discard_nxt = 1'b0;
                            w_addr_nxt    = r_pc;
                        end else begin
                            w_push   = 1'b1;
                            w_pc_nxt = r_addr + AW'(1);
                            if (w_cnt_after < CW1'(DEPTH)) begin
                                w_addr_nxt = r_addr + AW'(1);
                            end else begin
                                w_state_nxt = ST_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    fetch_queue #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_fetch_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_word (imem_rdata),
        .i_push_pc   (r_addr),
        .i_pop       (w_pop),
        .i_flush     (redirect),
        .o_head_word (inset),
        .o_head_pc   (inst_pc),
        .o_count     (w_q_count),
        .o_full      (w_q_full),
        .o_empty     (w_q_empty)
    );

endmodule
